// File: rtl/coded_tx_ctrl.sv
// coded_tx_ctrl: packet sequencer in front of the LE Coded TX FEC encoder.
// Inserts CI + TERM1 after the access address and TERM2 after the CRC;
// drives restart/bypass/coding_indicator; uncoded packets run in bypass.
// Ports: aclk, areset (sync, active-high); start/phy_coded/ci_cfg request;
//   busy/done/err status; in_t* upstream bit stream; enc_restart,
//   enc_bypass, enc_ci and enc_t* encoder stream.
// Optional macro CODED_TX_CTRL_STATS_EN adds pkt_cnt[15:0], err_cnt[7:0].
module coded_tx_ctrl #(
    parameter int AA_BITS   = 32,
    parameter int TERM_BITS = 3
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        phy_coded,
    input  logic [1:0]  ci_cfg,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    output logic        enc_restart,
    output logic        enc_bypass,
    output logic [1:0]  enc_ci,
    output logic        enc_tdata,
    output logic        enc_tvalid,
    input  logic        enc_tready,
    output logic        enc_tlast
`ifdef CODED_TX_CTRL_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
`endif
);

    localparam int MAXB = (AA_BITS > TERM_BITS) ? AA_BITS : TERM_BITS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam logic [CW-1:0] AA_LAST   = CW'(AA_BITS - 1);
    localparam logic [CW-1:0] TERM_LAST = CW'(TERM_BITS - 1);
    localparam logic [CW-1:0] CI_LAST   = CW'(1);

    typedef enum logic [2:0] {
        IDLE, PASS, AA, CI, TERM1, PDU, TERM2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    ci_q;
    // coding indicator used during TERM2; S8 when the packet ended in AA
    logic [1:0]    term_ci_q;
    logic          done_q, err_q;
    logic          done_d, err_d, moved;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        moved       = 1'b0;
        in_tready   = 1'b0;
        enc_tvalid  = 1'b0;
        enc_tdata   = 1'b0;
        enc_tlast   = 1'b0;
        enc_restart = 1'b0;
        enc_bypass  = 1'b0;
        enc_ci      = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    enc_restart = 1'b1;
                    state_d     = phy_coded ? AA : PASS;
                end
            end
            PASS: begin
                enc_bypass = 1'b1;
                enc_tvalid = in_tvalid;
                enc_tdata  = in_tdata;
                enc_tlast  = in_tlast;
                in_tready  = enc_tready;
                moved      = in_tvalid & enc_tready;
                if (moved && in_tlast) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            AA: begin
                enc_tvalid = in_tvalid;
                enc_tdata  = in_tdata;
                in_tready  = enc_tready;
                moved      = in_tvalid & enc_tready;
                if (moved) begin
                    if (in_tlast) begin
                        err_d   = 1'b1;
                        state_d = TERM2;
                    end else if (cnt_q == AA_LAST) begin
                        state_d = CI;
                    end
                end
            end
            CI: begin
                enc_tvalid = 1'b1;
                enc_tdata  = ci_q[cnt_q[0]];
                moved      = enc_tready;
                if (moved && cnt_q == CI_LAST)
                    state_d = TERM1;
            end
            TERM1: begin
                enc_tvalid = 1'b1;
                moved      = enc_tready;
                if (moved && cnt_q == TERM_LAST)
                    state_d = PDU;
            end
            PDU: begin
                enc_ci     = ci_q;
                enc_tvalid = in_tvalid;
                enc_tdata  = in_tdata;
                in_tready  = enc_tready;
                moved      = in_tvalid & enc_tready;
                if (moved && in_tlast)
                    state_d = TERM2;
            end
            TERM2: begin
                enc_ci     = term_ci_q;
                enc_tvalid = 1'b1;
                enc_tlast  = (cnt_q == TERM_LAST);
                moved      = enc_tready;
                if (moved && cnt_q == TERM_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ci_q      <= 2'd0;
            term_ci_q <= 2'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (moved)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == IDLE && start) begin
                ci_q      <= ci_cfg;
                term_ci_q <= ci_cfg;
            end
            if (err_d)
                term_ci_q <= 2'd0;
        end
    end

`ifdef CODED_TX_CTRL_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (done_q && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + 1'b1;
            if (err_q && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_coded_tx_ctrl.sv
// tb_coded_tx_ctrl: self-checking bench for coded_tx_ctrl.
// Random payloads/handshakes compared with a queue-based packet model.
module tb_coded_tx_ctrl;

    logic       aclk = 1'b0;
    logic       areset, start, phy_coded;
    logic [1:0] ci_cfg;
    logic       busy, done, err;
    logic       in_tdata, in_tvalid, in_tready, in_tlast;
    logic       enc_restart, enc_bypass;
    logic [1:0] enc_ci;
    logic       enc_tdata, enc_tvalid, enc_tready, enc_tlast;
`ifdef CODED_TX_CTRL_STATS_EN
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    coded_tx_ctrl dut (
        .aclk        (aclk),
        .areset      (areset),
        .start       (start),
        .phy_coded   (phy_coded),
        .ci_cfg      (ci_cfg),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .in_tlast    (in_tlast),
        .enc_restart (enc_restart),
        .enc_bypass  (enc_bypass),
        .enc_ci      (enc_ci),
        .enc_tdata   (enc_tdata),
        .enc_tvalid  (enc_tvalid),
        .enc_tready  (enc_tready),
        .enc_tlast   (enc_tlast)
`ifdef CODED_TX_CTRL_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_in_tready"}, in_tready, 0);
        check({tag, "_enc_tvalid"}, enc_tvalid, 0);
        check({tag, "_enc_tlast"}, enc_tlast, 0);
        check({tag, "_enc_restart"}, enc_restart, 0);
        check({tag, "_enc_bypass"}, enc_bypass, 0);
        check({tag, "_enc_ci"}, enc_ci, 0);
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 ready random
    // early: AA index carrying tlast (-1 none); rst_at: output bit count
    // after which areset hits (-1 none); spur_at: cycle of a stray start
    task automatic run_pkt(input bit coded, input logic [1:0] ci,
                           input int n_a, input int n_p, input int early,
                           input int mode, input int rst_at,
                           input int spur_at);
        bit         src[$];
        bit         ed[$];
        bit         el[$];
        bit         eg[$];
        logic [1:0] ec[$];
        int         nsrc, idx, k, err_k, cyc;
        bit         done_exp, err_exp, stalled, pdata, plast, fin, v, r;

        // reference packet: what the encoder must see, bit by bit
        if (!coded) begin
            for (int i = 0; i < n_a; i++) src.push_back(1'($urandom));
            foreach (src[i]) begin
                ed.push_back(src[i]); ec.push_back(2'd0);
                eg.push_back(0); el.push_back(i == n_a - 1);
            end
        end else if (early >= 0) begin
            for (int i = 0; i <= early; i++) src.push_back(1'($urandom));
            foreach (src[i]) begin
                ed.push_back(src[i]); ec.push_back(2'd0);
                eg.push_back(0); el.push_back(0);
            end
            for (int i = 0; i < 3; i++) begin
                ed.push_back(0); ec.push_back(2'd0);
                eg.push_back(1); el.push_back(i == 2);
            end
        end else begin
            for (int i = 0; i < n_a + n_p; i++)
                src.push_back(1'($urandom));
            for (int i = 0; i < n_a; i++) begin
                ed.push_back(src[i]); ec.push_back(2'd0);
                eg.push_back(0); el.push_back(0);
            end
            for (int i = 0; i < 5; i++) begin
                ed.push_back(i < 2 ? ci[i] : 1'b0); ec.push_back(2'd0);
                eg.push_back(1); el.push_back(0);
            end
            for (int i = n_a; i < n_a + n_p; i++) begin
                ed.push_back(src[i]); ec.push_back(ci);
                eg.push_back(0); el.push_back(0);
            end
            for (int i = 0; i < 3; i++) begin
                ed.push_back(0); ec.push_back(ci);
                eg.push_back(1); el.push_back(i == 2);
            end
        end
        nsrc  = src.size();
        err_k = (coded && early >= 0) ? early : -1;

        @(negedge aclk);
        start = 1; phy_coded = coded; ci_cfg = ci;
        in_tvalid = 0; in_tdata = 0; in_tlast = 0; enc_tready = 0;
        #2;
        check("restart_on_start", enc_restart, 1);
        check("busy_before_accept", busy, 0);
        @(negedge aclk);
        start = 0;
        phy_coded = 1'($urandom);
        ci_cfg = 2'($urandom);

        idx = 0; k = 0; done_exp = 0; err_exp = 0;
        stalled = 0; pdata = 0; plast = 0; fin = 0;
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge aclk);
            v = (idx < nsrc) && ($urandom_range(0, 3) != 0);
            r = (mode == 0) ? 1'b1 :
                (mode == 1) ? cyc[0] : 1'($urandom);
            in_tvalid  = v;
            in_tdata   = v ? src[idx] : 1'b0;
            in_tlast   = v && (idx == nsrc - 1);
            enc_tready = r;
            start      = (cyc == spur_at);
            #2;
            check("done", done, done_exp);
            check("err", err, err_exp);
            if (done_exp) begin
                check("busy_after_done", busy, 0);
                check("src_consumed", idx, nsrc);
                check("bits_out", k, ed.size());
                fin = 1;
            end else begin
                check("busy", busy, 1);
                check("restart_mid", enc_restart, 0);
                check("bypass", enc_bypass, !coded);
                if (stalled && k < ed.size() && eg[k]) begin
                    check("stall_valid", enc_tvalid, 1);
                    check("stall_data", enc_tdata, pdata);
                    check("stall_last", enc_tlast, plast);
                end
                done_exp = 0; err_exp = 0;
                if (k >= ed.size()) begin
                    check("extra_bit", enc_tvalid & enc_tready, 0);
                end else if (enc_tvalid && enc_tready) begin
                    check("enc_tdata", enc_tdata, ed[k]);
                    check("enc_tlast", enc_tlast, el[k]);
                    check("enc_ci", enc_ci, ec[k]);
                    done_exp = (k == ed.size() - 1);
                    err_exp  = (k == err_k);
                    k++;
                end
                stalled = enc_tvalid && !enc_tready;
                pdata   = enc_tdata;
                plast   = enc_tlast;
                if (in_tvalid && in_tready) idx++;
                if (k == rst_at && rst_at >= 0) begin
                    @(negedge aclk);
                    areset = 1; start = 0;
                    in_tvalid = 0; in_tlast = 0; enc_tready = 1;
                    @(negedge aclk);
                    areset = 0;
                    #2;
                    check_idle("mid_reset");
                    fin = 1;
                end
            end
        end
        check("pkt_finished", fin, 1);
        @(negedge aclk);
        start = 0; in_tvalid = 0; in_tlast = 0;
        #2;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        areset = 1; start = 0; phy_coded = 0; ci_cfg = 0;
        in_tdata = 0; in_tvalid = 0; in_tlast = 0; enc_tready = 1;
        repeat (2) @(negedge aclk);
        #2;
        check_idle("reset");
        @(negedge aclk);
        areset = 0;
        #2;
        check_idle("post_reset");

        run_pkt(1, 2'd0, 32, 40, -1, 0, -1, -1);
        run_pkt(1, 2'd1, 32, 24, -1, 1, -1, -1);
        run_pkt(0, 2'd1, 24, 0, -1, 2, -1, -1);
        run_pkt(1, 2'd1, 32, 0, 10, 2, -1, -1);
        run_pkt(1, 2'd0, 32, 0, 0, 1, -1, -1);
        run_pkt(1, 2'd1, 32, 0, 31, 0, -1, -1);
        run_pkt(1, 2'd1, 32, 40, -1, 2, 42, -1);
        run_pkt(1, 2'd1, 32, 16, -1, 2, -1, -1);
        run_pkt(1, 2'd0, 32, 40, -1, 0, -1, 50);
        run_pkt(0, 2'd0, 1, 0, -1, 0, -1, 5);
        for (int i = 0; i < 4; i++)
            run_pkt(1'($urandom), 2'($urandom_range(0, 1)), 32,
                    $urandom_range(1, 48), -1, 2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
